// File: rtl/dmem_pkg.sv
// Shared funct3 codes, FSM state encoding and a funct3 legality helper for the data-memory controller.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    if (we) ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory controller (slave).
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and replicated data, load extraction/extension, misalignment.
// No state, zero latency; has no handshake of its own.
import dmem_pkg::*;

module dmem_lane_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] rsh;

  // Bring the addressed byte/halfword down to bit 0 before extension.
  assign rsh = rword >> {byte_off, 3'b000};

  always_comb begin
    be        = 4'b0000;
    wdata_sh  = wdata;
    rdata_ext = rsh;
    misalign  = 1'b0;
    case (funct3[1:0])
      F3_B[1:0]: begin
        be        = 4'b0001 << byte_off;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{rsh[7] & ~funct3[2]}}, rsh[7:0]};
      end
      F3_H[1:0]: begin
        misalign  = byte_off[0];
        be        = 4'b0011 << {byte_off[1], 1'b0};
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = {{16{rsh[15] & ~funct3[2]}}, rsh[15:0]};
      end
      F3_W[1:0]: begin
        misalign  = |byte_off;
        be        = 4'b1111;
        rdata_ext = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// RV32 data-memory controller: response pulse 1+WAIT_STATES cycles after accept, req_ready low until back in IDLE.
// DMEM_CLEAR_ON_RST_EN: reset sweeps the array to zero one word per cycle before accepting requests.
import dmem_pkg::*;

module dmem_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t        state;
  logic [3:0]    cnt;
  logic          q_we;
  logic [2:0]    q_f3;
  logic [31:0]   q_addr;
  logic [31:0]   q_wdata;

  logic          a_we;
  logic [2:0]    a_f3;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic [AW-1:0] a_idx;
  logic          a_oor;
  logic          a_misalign;
  logic          a_err;
  logic          access;
  logic          wr_en;
  logic [3:0]    be;
  logic [31:0]   wdata_sh;
  logic [31:0]   rdata_ext;
  logic [31:0]   rword;
  logic [31:0]   rsp_rdata_nxt;

  logic [AW-1:0] clr_idx;
  logic          clr_we;

  logic [31:0]   mem [DEPTH];

  // With no wait states the access happens on the accept edge, so the live bus is used directly.
  assign a_we    = (state == IDLE) ? bus.req_we     : q_we;
  assign a_f3    = (state == IDLE) ? bus.req_funct3 : q_f3;
  assign a_addr  = (state == IDLE) ? bus.req_addr   : q_addr;
  assign a_wdata = (state == IDLE) ? bus.req_wdata  : q_wdata;

  assign a_idx  = a_addr[AW+1:2];
  assign a_oor  = |a_addr[31:AW+2];
  assign rword  = mem[a_idx];
  assign a_err  = a_oor | a_misalign | ~f3_legal(a_we, a_f3);
  assign access = ((state == IDLE) && bus.req_valid && (WAIT_STATES == 0)) ||
                  ((state == WAIT) && (cnt == 4'd0));
  assign wr_en  = access & a_we & ~a_err;
  assign rsp_rdata_nxt = (a_err | a_we) ? 32'd0 : rdata_ext;

  dmem_lane_align u_align (
    .funct3    (a_f3),
    .byte_off  (a_addr[1:0]),
    .wdata     (a_wdata),
    .rword     (rword),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .misalign  (a_misalign)
  );

`ifdef DMEM_CLEAR_ON_RST_EN
  assign clr_we = (state == CLEAR);
`else
  assign clr_idx = '0;
  assign clr_we  = 1'b0;
`endif

  // Writes are gated by rst so an aborted store never reaches the array.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_idx] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[a_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DMEM_CLEAR_ON_RST_EN
      state         <= CLEAR;
      bus.req_ready <= 1'b0;
      clr_idx       <= '0;
`else
      state         <= IDLE;
      bus.req_ready <= 1'b1;
`endif
      cnt           <= 4'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'd0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            q_we          <= bus.req_we;
            q_f3          <= bus.req_funct3;
            q_addr        <= bus.req_addr;
            q_wdata       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WS_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        CLEAR: begin
`ifdef DMEM_CLEAR_ON_RST_EN
          clr_idx <= clr_idx + 1'b1;
          if (&clr_idx) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
          end
`else
          state         <= IDLE;
          bus.req_ready <= 1'b1;
`endif
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase

      bus.rsp_valid <= access;
      if (access) begin
        bus.rsp_rdata <= rsp_rdata_nxt;
        bus.rsp_err   <= a_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: instances with WAIT_STATES 0 and 3 checked against a byte-array reference model.
// Define DMEM_CLEAR_ON_RST_EN to exercise the reset sweep.
module tb_dmem_ctrl;

  localparam int DEPTH  = 64;
  localparam int NBYTES = DEPTH * 4;
`ifdef DMEM_CLEAR_ON_RST_EN
  localparam logic RST_RDY = 1'b0;
`else
  localparam logic RST_RDY = 1'b1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst3, sel, t_valid, t_we;
  logic [2:0]  t_f3;
  logic [31:0] t_addr, t_wdata;
  logic        c_rdy, c_rv, c_err;
  logic [31:0] c_rd;
  int          ncmp = 0;
  int          nfail = 0;
  logic [7:0]  ref_mem [2][NBYTES];

  dmem_ctrl_if bus0 ();
  dmem_ctrl_if bus3 ();

  assign bus0.req_valid  = t_valid & ~sel;
  assign bus3.req_valid  = t_valid & sel;
  assign bus0.req_we     = t_we;
  assign bus3.req_we     = t_we;
  assign bus0.req_funct3 = t_f3;
  assign bus3.req_funct3 = t_f3;
  assign bus0.req_addr   = t_addr;
  assign bus3.req_addr   = t_addr;
  assign bus0.req_wdata  = t_wdata;
  assign bus3.req_wdata  = t_wdata;

  assign c_rdy = sel ? bus3.req_ready : bus0.req_ready;
  assign c_rv  = sel ? bus3.rsp_valid : bus0.rsp_valid;
  assign c_err = sel ? bus3.rsp_err   : bus0.rsp_err;
  assign c_rd  = sel ? bus3.rsp_rdata : bus0.rsp_rdata;

  dmem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0.slave));
  dmem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory seen as a flat little-endian byte array; a request touches 1, 2 or 4 bytes.
  function automatic void ref_txn(input int s, input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
    int          sz;
    logic        legal;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    sz    = 1 << f3[1:0];
    er    = !legal || ((a % sz) != 0) || (longint'(a) >= longint'(NBYTES));
    rd    = 32'd0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < sz; i++) ref_mem[s][a + i] = wd[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[s][a + i];
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
        rd = v;
      end
    end
  endfunction

  task automatic txn(input logic s, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input string tag,
                     output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic        eer;
    int          n;
    int          lat;
    logic        busy_ok;
    rd  = 32'hxxxx_xxxx;
    er  = 1'bx;
    sel = s;
    n   = 0;
    @(negedge clk);
    while (c_rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "-ready"}, 32'(c_rdy), 32'd1);
    if (c_rdy !== 1'b1) return;
    t_we = we; t_f3 = f3; t_addr = a; t_wdata = wd; t_valid = 1'b1;
    @(posedge clk);
    #1;
    // Garbage on the bus after accept must not disturb the pending request.
    t_valid = 1'b0;
    t_we    = 1'($urandom);
    t_f3    = 3'($urandom);
    t_addr  = $urandom;
    t_wdata = $urandom;
    ref_txn(int'(s), we, f3, a, wd, erd, eer);
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (c_rdy !== 1'b0) busy_ok = 1'b0;
    end while (c_rv !== 1'b1 && lat < 40);
    check({tag, "-latency"}, 32'(lat), s ? 32'd4 : 32'd1);
    check({tag, "-busy"}, 32'(busy_ok), 32'd1);
    check({tag, "-rdata"}, c_rd, erd);
    check({tag, "-err"}, 32'(c_err), 32'(eer));
    rd = c_rd;
    er = c_err;
    @(negedge clk);
    check({tag, "-pulse"}, 32'({c_rv, c_rdy}), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, wd, old;
    logic        er, s, we, seen;
    logic [2:0]  f3;
    int          n;

    for (int s2 = 0; s2 < 2; s2++)
      for (int b = 0; b < NBYTES; b++) ref_mem[s2][b] = 8'h00;
    sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_f3 = 3'd0; t_addr = 32'd0; t_wdata = 32'd0;
    rst0 = 1'b1; rst3 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst-ready0", 32'(bus0.req_ready), 32'(RST_RDY));
    check("rst-ready3", 32'(bus3.req_ready), 32'(RST_RDY));
    check("rst-rspvalid", 32'({bus0.rsp_valid, bus3.rsp_valid}), 32'd0);
    check("rst-rdata", bus0.rsp_rdata | bus3.rsp_rdata, 32'd0);
    check("rst-err", 32'({bus0.rsp_err, bus3.rsp_err}), 32'd0);
    @(posedge clk);
    #1;
    rst0 = 1'b0; rst3 = 1'b0;

`ifdef DMEM_CLEAR_ON_RST_EN
    n = 0;
    @(negedge clk);
    while (bus0.req_ready !== 1'b1 && n < 4 * DEPTH) begin
      n++;
      @(negedge clk);
    end
    check("clear-cycles", 32'(n), 32'(DEPTH));
    for (int w = 0; w < 4; w++) begin
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      txn(1'b0, 1'b0, 3'b010, a, 32'd0, "clear-lw", rd, er);
      check("clear-zero", rd, 32'd0);
    end
`endif

    for (int s2 = 0; s2 < 2; s2++)
      for (int w = 0; w < DEPTH; w++)
        txn(s2[0], 1'b1, 3'b010, 32'(w) << 2, $urandom, "init", rd, er);

    txn(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "t1-sw", rd, er);
    txn(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, "t1-lw", rd, er);
    check("t1-value", rd, 32'hDEADBEEF);

    txn(1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_0080, "t2-sb", rd, er);
    txn(1'b0, 1'b0, 3'b000, 32'h13, 32'd0, "t2-lb", rd, er);
    check("t2-lb-value", rd, 32'hFFFF_FF80);
    txn(1'b0, 1'b0, 3'b100, 32'h13, 32'd0, "t2-lbu", rd, er);
    check("t2-lbu-value", rd, 32'h0000_0080);
    txn(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, "t2-lw", rd, er);
    check("t2-lw-value", rd, 32'h80AD_BEEF);

    txn(1'b0, 1'b0, 3'b001, 32'h11, 32'd0, "t3-lh", rd, er);
    check("t3-lh-err", 32'({er, rd != 32'd0}), 32'd2);
    txn(1'b0, 1'b1, 3'b010, 32'h12, 32'h1111_1111, "t3-sw-mis", rd, er);
    check("t3-sw-mis-err", 32'(er), 32'd1);
    txn(1'b0, 1'b1, 3'b010, 32'(NBYTES), 32'h2222_2222, "t3-sw-oor", rd, er);
    check("t3-sw-oor-err", 32'(er), 32'd1);
    txn(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, "t3-lw", rd, er);
    check("t3-lw-value", rd, 32'h80AD_BEEF);

    for (int k = 0; k < 300; k++) begin
      s  = (k >= 200);
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin
        f3 = 3'($urandom);
      end else begin
        f3 = 3'($urandom_range(0, 2));
        if (!we && f3 != 3'd2 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
      end
      case ($urandom_range(0, 5))
        0:       a = 32'($urandom_range(0, NBYTES - 1));
        1:       a = 32'(NBYTES + $urandom_range(0, 1000));
        2:       a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(0, NBYTES - 1)) & ~((32'd1 << f3[1:0]) - 32'd1);
      endcase
      wd = $urandom;
      txn(s, we, f3, a, wd, s ? "rnd3" : "rnd0", rd, er);
    end

    // Store accepted, then reset in the following cycle: no response, no write.
    a   = 32'h20;
    old = {ref_mem[1][35], ref_mem[1][34], ref_mem[1][33], ref_mem[1][32]};
    sel = 1'b1;
    n   = 0;
    @(negedge clk);
    while (c_rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5-ready", 32'(c_rdy), 32'd1);
    t_we = 1'b1; t_f3 = 3'b010; t_addr = a; t_wdata = ~old; t_valid = 1'b1;
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    rst3    = 1'b1;
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus3.rsp_valid === 1'b1) seen = 1'b1;
    end
    check("t5-no-rsp", 32'(seen), 32'd0);
`ifdef DMEM_CLEAR_ON_RST_EN
    for (int b = 0; b < NBYTES; b++) ref_mem[1][b] = 8'h00;
`endif
    txn(1'b1, 1'b0, 3'b010, a, 32'd0, "t5-lw", rd, er);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
